// File: rtl/cplx_accum.sv
// Complex frame accumulator: sums N_TERMS signed complex terms into saturating
// accumulators and presents each frame sum through a valid/ready output register.
module cplx_accum #(
    parameter int WIDTH   = 16,
    parameter int ACC_W   = 24,
    parameter int N_TERMS = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_re,
    output logic [ACC_W-1:0] out_im,
    output logic             out_ovf
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    logic [ACC_W-1:0] accRe_q, accRe_d;
    logic [ACC_W-1:0] accIm_q, accIm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] outRe_q, outRe_d;
    logic [ACC_W-1:0] outIm_q, outIm_d;
    logic             outOvf_q, outOvf_d;
    logic             outValid_q, outValid_d;

    logic             inXfer;
    logic             outXfer;
    logic             lastTerm;
    logic [ACC_W:0]   addRe;
    logic [ACC_W:0]   addIm;

    // Returns {overflowed, saturated sum}; one guard bit detects leaving the ACC_W range.
    function automatic logic [ACC_W:0] satAdd(input logic [ACC_W-1:0] acc,
                                              input logic [WIDTH-1:0] term);
        logic [ACC_W:0] sum;
        sum = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - WIDTH){term[WIDTH-1]}}, term};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            return {1'b1, sum[ACC_W], {(ACC_W - 1){~sum[ACC_W]}}};
        end
        return {1'b0, sum[ACC_W-1:0]};
    endfunction

    always_comb begin
        in_ready = !(clr || ((cnt_q == LAST_CNT) && outValid_q && !out_ready));
        inXfer   = in_valid && in_ready;
        outXfer  = outValid_q && out_ready;
        lastTerm = inXfer && (cnt_q == LAST_CNT);
        addRe    = satAdd(accRe_q, in_re);
        addIm    = satAdd(accIm_q, in_im);
    end

    always_comb begin
        accRe_d    = accRe_q;
        accIm_d    = accIm_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        outRe_d    = outRe_q;
        outIm_d    = outIm_q;
        outOvf_d   = outOvf_q;
        outValid_d = outValid_q;

        if (outXfer) begin
            outValid_d = 1'b0;
        end

        // clr forces in_ready low, so it never coincides with an accepted term.
        if (clr) begin
            accRe_d = '0;
            accIm_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (lastTerm) begin
            outRe_d    = addRe[ACC_W-1:0];
            outIm_d    = addIm[ACC_W-1:0];
            outOvf_d   = ovf_q || addRe[ACC_W] || addIm[ACC_W];
            outValid_d = 1'b1;
            accRe_d    = '0;
            accIm_d    = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
        end else if (inXfer) begin
            accRe_d = addRe[ACC_W-1:0];
            accIm_d = addIm[ACC_W-1:0];
            cnt_d   = cnt_q + CNT_W'(1);
            ovf_d   = ovf_q || addRe[ACC_W] || addIm[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            accRe_q    <= '0;
            accIm_q    <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            outRe_q    <= '0;
            outIm_q    <= '0;
            outOvf_q   <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            accRe_q    <= accRe_d;
            accIm_q    <= accIm_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            outRe_q    <= outRe_d;
            outIm_q    <= outIm_d;
            outOvf_q   <= outOvf_d;
            outValid_q <= outValid_d;
        end
    end

    assign out_re    = outRe_q;
    assign out_im    = outIm_q;
    assign out_ovf   = outOvf_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_cplx_accum.sv
// Scoreboard bench for cplx_accum: a default instance (A) and an ACC_W=18 instance (B)
// share one stimulus stream; expected frame sums are queued and popped by a monitor.
module tb_cplx_accum;

    logic               clk = 1'b0;
    logic               rstn;
    logic               clr;
    logic               inValid;
    logic signed [15:0] inRe;
    logic signed [15:0] inIm;
    logic               outReady;

    logic               inReadyA, outValidA, outOvfA;
    logic [23:0]        outReA, outImA;
    logic               inReadyB, outValidB, outOvfB;
    logic [17:0]        outReB, outImB;

    typedef struct {
        longint re;
        longint im;
        longint ovf;
    } expT;

    expT qA[$];
    expT qB[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cplx_accum dutA (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(inValid), .in_ready(inReadyA), .in_re(inRe), .in_im(inIm),
        .out_valid(outValidA), .out_ready(outReady),
        .out_re(outReA), .out_im(outImA), .out_ovf(outOvfA)
    );

    cplx_accum #(.WIDTH(16), .ACC_W(18), .N_TERMS(8)) dutB (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(inValid), .in_ready(inReadyB), .in_re(inRe), .in_im(inIm),
        .out_valid(outValidB), .out_ready(outReady),
        .out_re(outReB), .out_im(outImB), .out_ovf(outOvfB)
    );

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pushExp(input longint reA, input longint imA, input longint ovfA,
                           input longint reB, input longint imB, input longint ovfB);
        expT e;
        e.re = reA; e.im = imA; e.ovf = ovfA;
        qA.push_back(e);
        e.re = reB; e.im = imB; e.ovf = ovfB;
        qB.push_back(e);
    endtask

    task automatic pushBoth(input longint re, input longint im);
        pushExp(re, im, 0, re, im, 0);
    endtask

    // Presents one term from posedge+1 and returns at posedge+1 after it is accepted.
    task automatic applyStimulus(input logic signed [15:0] re, input logic signed [15:0] im);
        int waited = 0;
        inValid = 1'b1;
        inRe    = re;
        inIm    = im;
        @(negedge clk);
        while (!(inReadyA && inReadyB) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!(inReadyA && inReadyB)) begin
            checkOutput("input accept timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic sendFrame(input int n, input logic signed [15:0] re, input logic signed [15:0] im);
        for (int i = 0; i < n; i++) begin
            applyStimulus(re, im);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Held outputs are compared against the queue head every cycle; popped on transfer.
    always @(negedge clk) begin
        if (rstn) begin
            if (outValidA) begin
                if (qA.size() == 0) begin
                    checkOutput("A unexpected output", 1, 0);
                end else begin
                    checkOutput("A out_re", longint'($signed(outReA)), qA[0].re);
                    checkOutput("A out_im", longint'($signed(outImA)), qA[0].im);
                    checkOutput("A out_ovf", longint'(outOvfA), qA[0].ovf);
                    if (outReady) void'(qA.pop_front());
                end
            end
            if (outValidB) begin
                if (qB.size() == 0) begin
                    checkOutput("B unexpected output", 1, 0);
                end else begin
                    checkOutput("B out_re", longint'($signed(outReB)), qB[0].re);
                    checkOutput("B out_im", longint'($signed(outImB)), qB[0].im);
                    checkOutput("B out_ovf", longint'(outOvfB), qB[0].ovf);
                    if (outReady) void'(qB.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn     = 1'b0;
        clr      = 1'b0;
        inValid  = 1'b0;
        inRe     = '0;
        inIm     = '0;
        outReady = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", longint'(inReadyA), 1);
        checkOutput("reset out_valid", longint'(outValidA), 0);
        checkOutput("reset out_re", longint'($signed(outReA)), 0);
        checkOutput("reset out_ovf", longint'(outOvfB), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame with latency-1, single-cycle out_valid.
        pushBoth(8, -16);
        sendFrame(8, 1, -2);
        checkOutput("basic valid latency", longint'(outValidA), 1);
        idle(1);
        checkOutput("basic valid one cycle", longint'(outValidA), 0);
        idle(2);

        // Saturation only in the 18-bit instance; the next zero frame must be clean.
        pushExp(262136, -262144, 0, 131071, -131072, 1);
        sendFrame(8, 32767, -32768);
        pushBoth(0, 0);
        sendFrame(8, 0, 0);
        idle(3);

        // Backpressure: 16 terms of (1,1) with the first sum held.
        outReady = 1'b0;
        pushBoth(8, 8);
        pushBoth(8, 8);
        sendFrame(15, 1, 1);
        inValid = 1'b1;
        inRe    = 1;
        inIm    = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall in_ready at last term", longint'(inReadyA), 0);
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
        applyStimulus(1, 1);
        checkOutput("backpressure valid kept", longint'(outValidA), 1);
        idle(3);

        // Output transfer in the same cycle as the next frame's final term.
        outReady = 1'b0;
        pushBoth(16, -8);
        sendFrame(8, 2, -1);
        pushBoth(24, 32);
        sendFrame(7, 3, 4);
        outReady = 1'b1;
        applyStimulus(3, 4);
        checkOutput("simultaneous valid kept", longint'(outValidB), 1);
        checkOutput("simultaneous new re", longint'($signed(outReA)), 24);
        idle(3);

        // Clear discards the partial frame and the term offered with it.
        sendFrame(3, 5, 5);
        clr     = 1'b1;
        inValid = 1'b1;
        inRe    = 9;
        inIm    = 9;
        @(negedge clk);
        checkOutput("clr in_ready", longint'(inReadyB), 0);
        @(posedge clk);
        #1;
        clr     = 1'b0;
        inValid = 1'b0;
        checkOutput("clr keeps out_valid", longint'(outValidA), 0);
        pushBoth(8, 0);
        sendFrame(8, 1, 0);
        idle(3);

        // Reset mid-frame with a sum pending.
        outReady = 1'b0;
        pushBoth(8, 8);
        sendFrame(8, 1, 1);
        sendFrame(5, 7, 7);
        rstn = 1'b0;
        #1;
        checkOutput("async reset out_valid A", longint'(outValidA), 0);
        checkOutput("async reset out_valid B", longint'(outValidB), 0);
        checkOutput("async reset out_re", longint'($signed(outReA)), 0);
        checkOutput("reset in_ready", longint'(inReadyA), 1);
        qA.delete();
        qB.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b1;
        pushBoth(16, 24);
        sendFrame(8, 2, 3);
        idle(4);

        checkOutput("scoreboard A drained", longint'(qA.size()), 0);
        checkOutput("scoreboard B drained", longint'(qB.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cplx_accum.md
CPLX_ACCUM -- requirements
Module: cplx_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the signed two's-complement width of each input component.
REQ-002 The block SHALL have parameter ACC_W, default 24, the signed accumulator and output component width, with ACC_W >= WIDTH+1.
REQ-003 The block SHALL have parameter N_TERMS, default 8, the number of complex products summed per output frame, with N_TERMS >= 2.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk input, rstn input.
REQ-005 Ports SHALL be:
- clk  in  1  rising-edge clock
- rstn  in  1  async active-low reset
- clr  in  1  synchronous abort of the current frame
- in_valid  in  1  input product valid
- in_ready  out  1  block can accept a product
- in_re  in  WIDTH  real part of complex product, signed
- in_im  in  WIDTH  imaginary part of complex product, signed
- out_valid  out  1  frame sum valid
- out_ready  in  1  downstream accepts the sum
- out_re  out  ACC_W  real frame sum, signed
- out_im  out  ACC_W  imaginary frame sum, signed
- out_ovf  out  1  saturation occurred in this frame

Function
REQ-006 A transfer SHALL occur on a rising clk edge when in_valid and in_ready are both high, and likewise when out_valid and out_ready are both high.
REQ-007 acc_re and acc_im SHALL each add the sign-extended in_re or in_im on every input transfer; term counter cnt (0..N_TERMS-1) SHALL increment per transfer.
REQ-008 Each addition SHALL saturate independently to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set a per-frame ovf flag; once saturated, later terms SHALL keep adding to the saturated value.
REQ-009 On the transfer with cnt == N_TERMS-1, the saturated sums SHALL go to out_re/out_im with the frame's ovf to out_ovf, out_valid SHALL be 1 the next cycle (latency 1), and acc, cnt, ovf SHALL clear to 0.
REQ-010 out_re, out_im, out_ovf SHALL be held stable while out_valid=1 and out_ready=0.
REQ-011 out_valid SHALL clear on an output transfer unless a new final term is accepted in the same cycle, in which case it SHALL stay 1 with the new frame's data.
REQ-012 in_ready SHALL be 0 only when (cnt == N_TERMS-1 and out_valid=1 and out_ready=0) or clr=1; otherwise it SHALL be 1, so the next frame accumulates while the previous sum waits.
REQ-013 in_ready SHALL depend combinationally only on registered state, out_ready and clr, never on in_valid.
REQ-014 clr=1 SHALL zero acc, cnt and ovf next cycle, discard any input presented that cycle, and leave the output register and out_valid untouched.
REQ-015 cnt SHALL wrap from N_TERMS-1 to 0 only as in REQ-009; no other wrap path SHALL exist.
REQ-016 in_re/in_im SHALL be ignored when in_valid=0, and out_ready SHALL be ignored when out_valid=0.

Reset
REQ-017 rstn low SHALL immediately and asynchronously force acc_re=acc_im=0, cnt=0, ovf=0, out_re=out_im=0, out_ovf=0, out_valid=0.
REQ-018 During reset in_ready SHALL read 1. Deassertion SHALL be synchronised externally; first transfer allowed on the first edge after rstn high.
REQ-019 Reset mid-frame SHALL discard the partial sum and any pending output without emitting it.

Verification
REQ-020 Basic: default params, out_ready=1, 8 transfers of (1,-2) -> one cycle after the 8th, out_valid=1 for one cycle with out_re=8, out_im=-16, out_ovf=0.
REQ-021 Saturation: ACC_W=18, 8 transfers of (32767,-32768) -> out_re=131071, out_im=-131072, out_ovf=1; next frame of 8x(0,0) -> (0,0), out_ovf=0.
REQ-022 Backpressure: out_ready=0, 16 back-to-back transfers of (1,1) -> first sum (8,8) held; in_ready=0 at cnt=7; raising out_ready -> (8,8) then (8,8) with no lost or duplicated term.
REQ-023 Simultaneous: out_valid=1 and out_ready=1 in the same cycle as the final term of the next frame -> out_valid stays 1, data updates to the new sum.
REQ-024 Clear: 3 transfers of (5,5), then clr=1 with in_valid=1 and (9,9), then 8x(1,0) -> output (8,0); (5,5) and (9,9) never appear.
REQ-025 Reset: rstn pulsed low after 5 transfers while a prior sum is pending -> out_valid=0 at once; the next 8x(2,3) -> (16,24).
